// File: rtl/duty_meter_pkg.sv
// rtl/duty_meter_pkg.sv - shared state encoding and duty-scale constants for duty_meter
package duty_meter_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DIVIDE  = 2'd2
    } dm_state_e;

    localparam int DM_M         = 26;
    localparam int DM_N         = 14;
    localparam int DM_FRAC      = DM_M - DM_N;
    // Duty value that represents 100 % high time.
    localparam int DM_DUTY_FULL = 1 << DM_FRAC;

endpackage

// File: rtl/duty_meter_sig_sync_edge.sv
// rtl/duty_meter_sig_sync_edge.sv - 2-FF synchroniser plus delay flop giving rise pulse and level
//
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset, clears all three flops
//   sig_i   asynchronous input
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   level_o synchronised level
module duty_meter_sig_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic level_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o  = s2_q & ~s3_q;
    assign level_o = s2_q;

endmodule

// File: rtl/duty_meter.sv
// rtl/duty_meter.sv - measures high time and period of sig_in and turns them into a Q1.FRAC duty via an external divider
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   en             measurement enable; low aborts to SYNC
//   sig_in         asynchronous signal under measurement
//   div_dividend   {high count, FRAC zeros} to the divider
//   div_divisor    period count to the divider
//   div_quotient   divider result
//   duty           high/period ratio, full scale = 2^FRAC
//   duty_valid     one-cycle pulse when duty updates
//   overflow       one-cycle pulse when the period exceeds 2^N-1 cycles
//   busy           high while measuring or dividing
module duty_meter
    import duty_meter_pkg::*;
#(
    parameter int M       = DM_M,
    parameter int N       = DM_N,
    parameter int DIV_LAT = M
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           sig_in,
    output logic [M-1:0]   div_dividend,
    output logic [N-1:0]   div_divisor,
    input  logic [M-1:0]   div_quotient,
    output logic [M-N:0]   duty,
    output logic           duty_valid,
    output logic           overflow,
    output logic           busy
);

    localparam int FRAC = M - N;
    localparam int LW   = $clog2(DIV_LAT + 1);

    localparam logic [N-1:0]  PERIOD_MAX = {N{1'b1}};
    localparam logic [FRAC:0] DUTY_FULL  = {1'b1, {FRAC{1'b0}}};

    logic rise;
    logic level;

    duty_meter_sig_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_i   (sig_in),
        .rise_o  (rise),
        .level_o (level)
    );

    dm_state_e     state_q, state_d;
    logic [N-1:0]  period_q, period_d;
    logic [N-1:0]  high_q, high_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [M-1:0]  dividend_q, dividend_d;
    logic [N-1:0]  divisor_q, divisor_d;
    logic [FRAC:0] duty_q, duty_d;
    logic          duty_valid_q, duty_valid_d;
    logic          overflow_q, overflow_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            period_q     <= '0;
            high_q       <= '0;
            lat_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            high_q       <= high_d;
            lat_q        <= lat_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        high_d       = high_q;
        lat_d        = lat_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        overflow_d   = 1'b0;

        if (!en) begin
            // Abort quietly: duty and divider operands keep their last values.
            state_d  = ST_SYNC;
            period_d = '0;
            high_d   = '0;
            lat_d    = '0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (rise) begin
                        // The rise cycle itself is the first cycle of the new period, and it is high.
                        period_d = {{(N-1){1'b0}}, 1'b1};
                        high_d   = {{(N-1){1'b0}}, 1'b1};
                        state_d  = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        dividend_d = {high_q, {FRAC{1'b0}}};
                        divisor_d  = period_q;
                        lat_d      = '0;
                        state_d    = ST_DIVIDE;
                    end else if (period_q == PERIOD_MAX) begin
                        overflow_d = 1'b1;
                        period_d   = '0;
                        high_d     = '0;
                        state_d    = ST_SYNC;
                    end else begin
                        period_d = period_q + {{(N-1){1'b0}}, 1'b1};
                        high_d   = high_q + {{(N-1){1'b0}}, level};
                    end
                end
                ST_DIVIDE: begin
                    // Operands stay frozen here; the divider needs them stable for DIV_LAT edges.
                    if (lat_q == LW'(DIV_LAT)) begin
                        // high <= period keeps the quotient within FRAC+1 bits; saturate if it ever is not.
                        duty_d       = (|div_quotient[M-1:FRAC+1]) ? DUTY_FULL : div_quotient[FRAC:0];
                        duty_valid_d = 1'b1;
                        state_d      = ST_SYNC;
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign duty         = duty_q;
    assign duty_valid   = duty_valid_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != ST_SYNC);

endmodule

// File: tb/tb_duty_meter.sv
// tb/tb_duty_meter.sv - self-checking bench for duty_meter with a behavioural divider
module tb_duty_meter;
    import duty_meter_pkg::*;

    localparam int M       = 26;
    localparam int N       = 14;
    localparam int FRAC    = M - N;
    localparam int DIV_LAT = M;
    // sig_in to duty_valid: two synchroniser edges, then DIV_LAT+2 from the internal rise.
    localparam int EXP_LAT = DIV_LAT + 4;
    localparam logic [M-1:0] GARBAGE = 26'h155_5555;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           sig_in = 1'b0;
    logic [M-1:0]   div_dividend;
    logic [N-1:0]   div_divisor;
    logic [M-1:0]   div_quotient;
    logic [FRAC:0]  duty;
    logic           duty_valid;
    logic           overflow;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int last_exp = 0;

    always #5 clk = ~clk;

    duty_meter #(.M(M), .N(N), .DIV_LAT(DIV_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sig_in       (sig_in),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .overflow     (overflow),
        .busy         (busy)
    );

    // Divider model: the quotient is only correct once the operands have been
    // stable long enough; anything captured earlier sees a garbage value.
    int           stab = 0;
    logic [M-1:0] prev_dd = '0;
    logic [N-1:0] prev_dv = '0;

    always @(posedge clk) begin
        if (div_dividend == prev_dd && div_divisor == prev_dv) stab <= stab + 1;
        else stab <= 0;
        prev_dd <= div_dividend;
        prev_dv <= div_divisor;
    end

    always_comb begin
        div_quotient = GARBAGE;
        if (div_divisor != '0 && stab >= DIV_LAT - 1)
            div_quotient = div_dividend / {{(M-N){1'b0}}, div_divisor};
    end

    function automatic int ratio(input int h, input int l);
        return (h * DM_DUTY_FULL) / (h + l);
    endfunction

    task automatic drive_period(input int h, input int l);
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
        sig_in = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) sig_in = 1'b0;
            if (duty_valid) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (div_dividend !== '0) begin errors++; $display("FAIL reset_dividend: got %0d want 0", div_dividend); end
        checks++; if (div_divisor !== '0) begin errors++; $display("FAIL reset_divisor: got %0d want 0", div_divisor); end
        checks++; if (duty !== '0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty); end
        checks++; if (duty_valid !== 1'b0) begin errors++; $display("FAIL reset_duty_valid: got %b want 0", duty_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        sig_in = 1'b0;
        rst_n  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_repeating();
        int nv = 0;
        int run = 0;
        int maxrun = 0;
        for (int c = 0; c < 180; c++) begin
            sig_in = (c < 120) && ((c % 8) < 3);
            @(negedge clk);
            if (duty_valid) begin
                nv++;
                run++;
                if (run > maxrun) maxrun = run;
                checks++; if (duty !== 13'd1536) begin errors++; $display("FAIL rep_duty: got %0d want 1536", duty); end
                checks++; if (div_divisor !== 14'd8) begin errors++; $display("FAIL rep_divisor: got %0d want 8", div_divisor); end
                checks++; if (div_dividend !== (26'd3 << FRAC)) begin errors++; $display("FAIL rep_dividend: got %0d want %0d", div_dividend, 3 << FRAC); end
            end else begin
                run = 0;
            end
        end
        checks++; if (nv < 2) begin errors++; $display("FAIL rep_count: got %0d results want >=2", nv); end
        checks++; if (maxrun != 1) begin errors++; $display("FAIL rep_pulse_width: got %0d cycles want 1", maxrun); end
        last_exp = 1536;
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed_ratios();
        int hs[3] = '{10, 1, 7};
        int ls[3] = '{10, 1, 1};
        int ex[3] = '{2048, 2048, 3584};
        bit got;
        int lat;
        for (int k = 0; k < 3; k++) begin
            drive_period(hs[k], ls[k]);
            wait_valid(EXP_LAT + 20, got, lat);
            checks++; if (!got) begin errors++; $display("FAIL fixed_timeout %0d/%0d: no duty_valid", hs[k], ls[k]); end
            checks++; if (duty !== ex[k][FRAC:0]) begin errors++; $display("FAIL fixed_duty %0d/%0d: got %0d want %0d", hs[k], ls[k], duty, ex[k]); end
            checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL fixed_latency %0d/%0d: got %0d want %0d", hs[k], ls[k], lat, EXP_LAT); end
            @(negedge clk);
            checks++; if (duty_valid !== 1'b0) begin errors++; $display("FAIL fixed_pulse %0d/%0d: duty_valid still %b want 0", hs[k], ls[k], duty_valid); end
            last_exp = ex[k];
        end
    endtask

    task automatic test_en_abort();
        bit got;
        int lat;
        int nv = 0;
        drive_period(1, 3);
        @(negedge clk);
        sig_in = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (duty_valid) nv++;
            @(negedge clk);
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", nv); end
        checks++; if (duty !== last_exp[FRAC:0]) begin errors++; $display("FAIL abort_duty_kept: got %0d want %0d", duty, last_exp); end
        en = 1'b1;
        @(negedge clk);
        drive_period(5, 3);
        wait_valid(EXP_LAT + 20, got, lat);
        checks++; if (!got || duty !== 13'd2560) begin errors++; $display("FAIL abort_resume: got %0d (valid %b) want 2560", duty, got); end
        last_exp = 2560;
    endtask

    task automatic test_reset_mid();
        bit got;
        int lat;
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_measuring: busy %b want 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (div_dividend !== '0) begin errors++; $display("FAIL rstmid_dividend: got %0d want 0", div_dividend); end
        checks++; if (div_divisor !== '0) begin errors++; $display("FAIL rstmid_divisor: got %0d want 0", div_divisor); end
        checks++; if (duty !== '0) begin errors++; $display("FAIL rstmid_duty: got %0d want 0", duty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (duty_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: valid %b ovf %b want 0 0", duty_valid, overflow); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        drive_period(6, 2);
        wait_valid(EXP_LAT + 20, got, lat);
        checks++; if (!got || duty !== 13'd3072) begin errors++; $display("FAIL rstmid_first: got %0d (valid %b) want 3072", duty, got); end
        last_exp = 3072;
    endtask

    task automatic test_overflow();
        int t_ovf = 0;
        int nv = 0;
        int n_ovf = 0;
        sig_in = 1'b1;
        for (int i = 1; i <= 17000; i++) begin
            @(negedge clk);
            if (duty_valid) nv++;
            if (overflow) begin
                n_ovf++;
                if (t_ovf == 0) t_ovf = i;
            end
            if (t_ovf != 0 && i > t_ovf + 3) break;
        end
        checks++; if (t_ovf != (1 << N) - 1 + 3) begin errors++; $display("FAIL ovf_time: got %0d want %0d", t_ovf, (1 << N) - 1 + 3); end
        checks++; if (n_ovf != 1) begin errors++; $display("FAIL ovf_pulse: got %0d cycles want 1", n_ovf); end
        checks++; if (nv != 0) begin errors++; $display("FAIL ovf_no_valid: got %0d pulses want 0", nv); end
        checks++; if (duty !== last_exp[FRAC:0]) begin errors++; $display("FAIL ovf_duty_kept: got %0d want %0d", duty, last_exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b want 0", busy); end
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit got;
        int lat;
        int nv = 0;
        int vlat = 0;
        logic [FRAC:0] vduty = '0;
        drive_period(2, 6);
        // Fast 1/1 toggling while the first result is being divided, then a quiet gap.
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            sig_in = (i < 20) && (i % 2 == 0);
            if (duty_valid) begin
                nv++;
                vlat  = i;
                vduty = duty;
            end
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL b2b_count: got %0d results want 1", nv); end
        checks++; if (vduty !== 13'd1024) begin errors++; $display("FAIL b2b_first: got %0d want 1024", vduty); end
        checks++; if (vlat != EXP_LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", vlat, EXP_LAT); end
        drive_period(5, 3);
        wait_valid(EXP_LAT + 20, got, lat);
        checks++; if (!got || duty !== 13'd2560) begin errors++; $display("FAIL b2b_next: got %0d (valid %b) want 2560", duty, got); end
        last_exp = 2560;
    endtask

    task automatic test_random();
        bit got;
        int lat;
        int h;
        int l;
        int e;
        for (int k = 0; k < 8; k++) begin
            h = $urandom_range(1, 50);
            l = $urandom_range(1, 50);
            e = ratio(h, l);
            drive_period(h, l);
            wait_valid(EXP_LAT + 20, got, lat);
            checks++; if (!got) begin errors++; $display("FAIL rnd_timeout %0d/%0d: no duty_valid", h, l); end
            checks++; if (duty !== e[FRAC:0]) begin errors++; $display("FAIL rnd_duty %0d/%0d: got %0d want %0d", h, l, duty, e); end
            checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL rnd_latency %0d/%0d: got %0d want %0d", h, l, lat, EXP_LAT); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy %0d/%0d: got %b want 0", h, l, busy); end
            last_exp = e;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_repeating();
        test_fixed_ratios();
        test_en_abort();
        test_reset_mid();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
